// File: rtl/morse_key_decoder_if.sv
// Symbol bus between the Morse key decoder and its consumer.
//   key_in    : raw key level into the decoder, 1 = pressed
//   sym_valid : one-cycle strobe, sym_* fields valid this cycle
//   sym_len   : element count of the character (0 when sym_err)
//   sym_bits  : element i at bit i, 1 = dash, 0 = dot
//   sym_err   : character had more than MAX_ELEMS elements
//   word_gap  : one-cycle strobe at a word boundary
interface morse_key_decoder_if #(
    parameter int unsigned MAX_ELEMS = 6
) ();
    logic                 key_in;
    logic                 sym_valid;
    logic [2:0]           sym_len;
    logic [MAX_ELEMS-1:0] sym_bits;
    logic                 sym_err;
    logic                 word_gap;

    // Decoder side
    modport master (
        input  key_in,
        output sym_valid, sym_len, sym_bits, sym_err, word_gap
    );

    // Key source / symbol consumer side
    modport slave (
        output key_in,
        input  sym_valid, sym_len, sym_bits, sym_err, word_gap
    );
endinterface

// File: rtl/morse_key_decoder.sv
// Morse key decoder: synchronizes and debounces a raw key, measures mark and
// space lengths in Morse units, classifies dots/dashes and emits one symbol
// strobe per character plus a word-boundary strobe.
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : morse_key_decoder_if.master (key_in in, sym_*/word_gap out)
module morse_key_decoder #(
    parameter int unsigned UNIT_CYCLES     = 1250000,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned MAX_ELEMS       = 6
) (
    input  logic                clk,
    input  logic                rst,
    morse_key_decoder_if.master bus
);
    localparam int unsigned UCNT_W = $clog2(UNIT_CYCLES);
    localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned DUR_W  = 4;
    localparam int unsigned LEN_W  = 3;

    typedef enum logic [1:0] {IDLE, MARK, SPACE} state_t;

    state_t               state, state_next;
    logic                 sync0, sync1, key_db, key_db_d;
    logic [DB_W-1:0]      db_cnt;
    logic [UCNT_W-1:0]    ucnt;
    logic [DUR_W-1:0]     dur;
    logic [LEN_W-1:0]     len, len_next;
    logic [MAX_ELEMS-1:0] bits, bits_next;
    logic                 ovf, ovf_next;
    logic                 sym_valid_next, sym_err_next, word_gap_next;
    logic [LEN_W-1:0]     sym_len_next;
    logic [MAX_ELEMS-1:0] sym_bits_next;
    logic                 rise_c, fall_c, edge_c, tick_c, dash_c;
    logic [DUR_W-1:0]     dur_inc_c;

    // Two-flop synchronizer and debounce: key_db follows only a stable level
    always_ff @(posedge clk) begin
        if (rst) begin
            sync0    <= 1'b0;
            sync1    <= 1'b0;
            key_db   <= 1'b0;
            key_db_d <= 1'b0;
            db_cnt   <= '0;
        end else begin
            sync0    <= bus.key_in;
            sync1    <= sync0;
            key_db_d <= key_db;
            if (sync1 == key_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                key_db <= sync1;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    assign rise_c    = key_db & ~key_db_d;
    assign fall_c    = ~key_db & key_db_d;
    assign edge_c    = rise_c | fall_c;
    assign tick_c    = (state != IDLE) && (ucnt == UCNT_W'(UNIT_CYCLES - 1));
    // Duration including a tick in this same cycle, saturating at 15
    assign dur_inc_c = (tick_c && (dur != DUR_W'(15))) ? dur + DUR_W'(1) : dur;
    assign dash_c    = (dur >= DUR_W'(2));

    // Unit timer: idle in IDLE, restarted on every debounced edge
    always_ff @(posedge clk) begin
        if (rst || (state_next == IDLE) || edge_c) begin
            ucnt <= '0;
            dur  <= '0;
        end else begin
            ucnt <= tick_c ? '0 : ucnt + UCNT_W'(1);
            dur  <= dur_inc_c;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state, element buffer and symbol outputs
    always_comb begin
        state_next     = state;
        len_next       = len;
        bits_next      = bits;
        ovf_next       = ovf;
        sym_valid_next = 1'b0;
        sym_len_next   = bus.sym_len;
        sym_bits_next  = bus.sym_bits;
        sym_err_next   = bus.sym_err;
        word_gap_next  = 1'b0;
        case (state)
            IDLE: begin
                if (rise_c) state_next = MARK;
            end
            MARK: begin
                if (fall_c) begin
                    if (len < LEN_W'(MAX_ELEMS)) begin
                        bits_next = bits | (MAX_ELEMS'(dash_c) << len);
                        len_next  = len + LEN_W'(1);
                    end else begin
                        ovf_next = 1'b1;
                    end
                    state_next = SPACE;
                end
            end
            SPACE: begin
                // Character gap: emit and empty the buffer before any new mark
                if (tick_c && (dur_inc_c == DUR_W'(3)) && ((len != '0) || ovf)) begin
                    sym_valid_next = 1'b1;
                    sym_err_next   = ovf;
                    sym_len_next   = ovf ? '0 : len;
                    sym_bits_next  = ovf ? '0 : bits;
                    len_next       = '0;
                    bits_next      = '0;
                    ovf_next       = 1'b0;
                end
                if (tick_c && (dur_inc_c == DUR_W'(7))) begin
                    word_gap_next = 1'b1;
                    state_next    = IDLE;
                end
                // A rise always starts a mark; the buffer is kept unless just emitted
                if (rise_c) state_next = MARK;
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered buffer and outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            len          <= '0;
            bits         <= '0;
            ovf          <= 1'b0;
            bus.sym_valid <= 1'b0;
            bus.sym_len   <= '0;
            bus.sym_bits  <= '0;
            bus.sym_err   <= 1'b0;
            bus.word_gap  <= 1'b0;
        end else begin
            len          <= len_next;
            bits         <= bits_next;
            ovf          <= ovf_next;
            bus.sym_valid <= sym_valid_next;
            bus.sym_len   <= sym_len_next;
            bus.sym_bits  <= sym_bits_next;
            bus.sym_err   <= sym_err_next;
            bus.word_gap  <= word_gap_next;
        end
    end
endmodule

// File: tb/tb_morse_key_decoder.sv
// Bench for morse_key_decoder: directed Morse patterns plus random key runs,
// checked every cycle against a run-length model of the key timing rules.
module tb_morse_key_decoder;
    localparam int U   = 8;
    localparam int DEB = 2;
    localparam int ME  = 6;
    // Latency from the first raw sample of an event to the visible strobe
    localparam int LAT = DEB + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    morse_key_decoder_if #(.MAX_ELEMS(ME)) bus ();

    morse_key_decoder #(
        .UNIT_CYCLES(U), .DEBOUNCE_CYCLES(DEB), .MAX_ELEMS(ME)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef struct {
        int t;
        bit word;
        int len;
        int bits;
        bit err;
    } ev_t;

    int  checks = 0;
    int  passed = 0;
    int  cyc    = 0;
    ev_t evq[$];

    // Model state
    bit win[$];
    bit filt      = 1'b0;
    int mst       = 0;          // 0 idle, 1 inside a mark, 2 inside a space
    int t_rise    = 0;
    int t_fall    = 0;
    int elems[$];
    bit movf      = 1'b0;
    bit rst_seen  = 1'b1;

    // Logs for the directed literal checks
    int m_len[$], m_bits[$], m_err[$], m_words;
    int o_len[$], o_bits[$], o_err[$], o_sym_t[$], o_word_t[$];

    task automatic check(string name, int act, int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    endtask

    function automatic void clear_logs();
        m_len.delete(); m_bits.delete(); m_err.delete(); m_words = 0;
        o_len.delete(); o_bits.delete(); o_err.delete();
        o_sym_t.delete(); o_word_t.delete();
    endfunction

    function automatic void emit(int tf);
        ev_t e;
        int  b = 0;
        foreach (elems[i]) b = b | (elems[i] << i);
        e.t    = tf + LAT;
        e.word = 1'b0;
        e.err  = movf;
        e.len  = movf ? 0 : elems.size();
        e.bits = movf ? 0 : b;
        evq.push_back(e);
        m_len.push_back(e.len); m_bits.push_back(e.bits); m_err.push_back(int'(e.err));
        elems.delete();
        movf = 1'b0;
    endfunction

    // One step of the filtered key timeline at filtered time tf
    function automatic void model_step(int tf, bit lvl);
        ev_t e;
        int  k;
        int  mark_len;
        if (mst == 2) begin
            k = tf - t_fall;
            if (k == 3 * U && (elems.size() != 0 || movf)) emit(tf);
            if (k == 7 * U) begin
                e.t = tf + LAT; e.word = 1'b1; e.len = 0; e.bits = 0; e.err = 1'b0;
                evq.push_back(e);
                m_words++;
                mst = 0;
            end
        end
        if (lvl != filt) begin
            filt = lvl;
            if (lvl) begin
                if (mst != 1) begin
                    mst    = 1;
                    t_rise = tf;
                end
            end else if (mst == 1) begin
                // Whole units completed before the release decide dot or dash
                mark_len = tf - t_rise;
                if (elems.size() < ME) elems.push_back(((mark_len - 1) / U >= 2) ? 1 : 0);
                else movf = 1'b1;
                mst    = 2;
                t_fall = tf;
            end
        end
    endfunction

    // Model: a level is accepted once DEB consecutive samples agree, dated at its first sample
    always @(posedge clk) begin
        bit v;
        bit same;
        cyc = cyc + 1;
        if (rst) begin
            rst_seen = 1'b1;
            win.delete();
            evq.delete();
            elems.delete();
            filt = 1'b0;
            mst  = 0;
            movf = 1'b0;
        end else begin
            rst_seen = 1'b0;
            win.push_back(bus.key_in);
            if (win.size() == DEB) begin
                v    = win[0];
                same = 1'b1;
                foreach (win[i]) if (win[i] != v) same = 1'b0;
                model_step(cyc - (DEB - 1), (same && v != filt) ? v : filt);
                void'(win.pop_front());
            end
        end
    end

    // Compare process: every output, every cycle
    int h_len = 0, h_bits = 0, h_err = 0;
    always @(negedge clk) begin
        ev_t e;
        int  exp_sym;
        int  exp_word;
        if (cyc > 0) begin
            exp_sym  = 0;
            exp_word = 0;
            if (rst_seen) begin
                h_len = 0; h_bits = 0; h_err = 0;
            end
            while (evq.size() > 0 && evq[0].t == cyc) begin
                e = evq.pop_front();
                if (e.word) exp_word = 1;
                else begin
                    exp_sym = 1;
                    h_len = e.len; h_bits = e.bits; h_err = int'(e.err);
                end
            end
            if (bus.sym_valid === 1'b1) begin
                o_len.push_back(int'(bus.sym_len));
                o_bits.push_back(int'(bus.sym_bits));
                o_err.push_back(int'(bus.sym_err));
                o_sym_t.push_back(cyc);
            end
            if (bus.word_gap === 1'b1) o_word_t.push_back(cyc);
            check("sym_valid", int'(bus.sym_valid), exp_sym);
            check("word_gap",  int'(bus.word_gap),  exp_word);
            check("sym_len",   int'(bus.sym_len),   h_len);
            check("sym_bits",  int'(bus.sym_bits),  h_bits);
            check("sym_err",   int'(bus.sym_err),   h_err);
        end
    end

    task automatic drive(bit v, int n);
        bus.key_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic dots(int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, U);
            if (i != n - 1) drive(1'b0, U);
        end
    endtask

    initial begin
        int rel;
        int ml;
        int sl;
        bus.key_in = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 10);

        // 'A': dot, dash
        clear_logs();
        drive(1'b1, U); drive(1'b0, U); drive(1'b1, 3 * U);
        rel = cyc + 1;
        drive(1'b0, 80);
        check("A_count", o_len.size(), 1);
        if (o_len.size() == 1) begin
            check("A_len",   o_len[0], 2);
            check("A_bits",  o_bits[0], 6'b000010);
            check("A_err",   o_err[0], 0);
            check("A_sym_t", o_sym_t[0] - rel, 28);
        end
        check("A_words", o_word_t.size(), 1);
        if (o_word_t.size() == 1) check("A_word_t", o_word_t[0] - rel, 60);
        check("A_model_n", m_len.size(), 1);
        if (m_len.size() == 1) check("A_model_bits", m_bits[0], 2);

        // 'S' then 'T', character gap of exactly three units
        clear_logs();
        dots(3);
        drive(1'b0, 3 * U); drive(1'b1, 3 * U); drive(1'b0, 80);
        check("ST_count", o_len.size(), 2);
        if (o_len.size() == 2) begin
            check("S_len", o_len[0], 3);
            check("S_bits", o_bits[0], 0);
            check("T_len", o_len[1], 1);
            check("T_bits", o_bits[1], 1);
        end
        check("ST_words", o_word_t.size(), 1);
        check("ST_model_words", m_words, 1);

        // Single-cycle glitches
        clear_logs();
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 1); drive(1'b0, 4);
        end
        drive(1'b0, 20);
        check("glitch_syms", o_len.size(), 0);
        check("glitch_words", o_word_t.size(), 0);

        // Overflow then a normal character
        clear_logs();
        dots(7);
        drive(1'b0, 80);
        check("ovf_count", o_len.size(), 1);
        if (o_len.size() == 1) begin
            check("ovf_err",  o_err[0], 1);
            check("ovf_len",  o_len[0], 0);
            check("ovf_bits", o_bits[0], 0);
        end
        check("ovf_model_err", (m_err.size() == 1) ? m_err[0] : -1, 1);
        clear_logs();
        drive(1'b1, U); drive(1'b0, U); drive(1'b1, 3 * U); drive(1'b0, 80);
        check("post_ovf_count", o_len.size(), 1);
        if (o_len.size() == 1) begin
            check("post_ovf_len",  o_len[0], 2);
            check("post_ovf_bits", o_bits[0], 2);
            check("post_ovf_err",  o_err[0], 0);
        end

        // Reset in the middle of a held mark
        clear_logs();
        drive(1'b1, 20);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 80);
        check("rst_syms", o_len.size(), 0);
        check("rst_words", o_word_t.size(), 0);

        // Long hold saturates the duration and is still a dash
        clear_logs();
        drive(1'b1, 160); drive(1'b0, 80);
        check("hold_count", o_len.size(), 1);
        if (o_len.size() == 1) begin
            check("hold_len",  o_len[0], 1);
            check("hold_bits", o_bits[0], 1);
        end

        // Random key runs, including boundary lengths and short glitches
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 3))
                0:       ml = 2 * U;
                1:       ml = 2 * U + 1;
                default: ml = int'($urandom_range(1, 4 * U));
            endcase
            case ($urandom_range(0, 7))
                0:       sl = 3 * U;
                1:       sl = 3 * U - 1;
                2:       sl = 3 * U + 1;
                3:       sl = 7 * U;
                4:       sl = 7 * U - 1;
                default: sl = int'($urandom_range(1, 9 * U));
            endcase
            drive(1'b1, ml);
            drive(1'b0, sl);
        end
        drive(1'b0, 80);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
